mcpu_vram_arbiter: RTL and testbench

Bus arbiter between the MCPU core's memory port and the two data-side memories: DRAM and GPU VRAM. DRAM accesses pass straight through with zero wait. VRAM accesses are allowed only while the GPU is not scanning out (display_on=0). CPU writes to VRAM are buffered in a write FIFO and drained during blanking. CPU reads from VRAM stall the core until the FIFO is empty and blanking allows a read.

---
 rtl/mcpu_bus_pkg.sv | 23 ++
 rtl/mcpu_vram_arbiter_if.sv | 37 +++
 rtl/mcpu_sync_fifo.sv | 49 ++++
 rtl/mcpu_vram_arbiter.sv | 125 ++++++++++++
 tb/tb_mcpu_vram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcpu_bus_pkg.sv
// Shared definitions for the MCPU data-side bus: region codes, arbiter FSM
// state encoding and VRAM write-buffer entry sizing.
package mcpu_bus_pkg;

  localparam logic [1:0] REGION_DRAM = 2'b00;
  localparam logic [1:0] REGION_VRAM = 2'b01;

  localparam int unsigned VRAM_AW_DEFAULT = 13;
  // One buffered write is {vram address, 8-bit data}.
  localparam int unsigned FIFO_ENTRY_W = VRAM_AW_DEFAULT + 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRdPend  = 2'd1,
    StRdIssue = 2'd2,
    StRdDone  = 2'd3
  } arb_state_e;

  function automatic int unsigned fifo_entry_w(int unsigned vram_aw);
    return vram_aw + 8;
  endfunction

endpackage

// File: rtl/mcpu_vram_arbiter_if.sv
// Bus bundle around the VRAM arbiter: CPU port, DRAM port, VRAM port and the
// display_on / fifo_level side signals. slave = arbiter, master = system side.
interface mcpu_vram_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned VRAM_AW    = 13,
  parameter int unsigned FIFO_DEPTH = 4
);
  logic                        display_on;
  logic [DATA_WIDTH-1:0]       cpu_addr;
  logic [DATA_WIDTH-1:0]       cpu_wdata;
  logic                        cpu_we;
  logic                        cpu_re;
  logic [DATA_WIDTH-1:0]       cpu_rdata;
  logic                        cpu_wait;
  logic [DATA_WIDTH-3:0]       dram_addr;
  logic                        dram_we;
  logic                        dram_re;
  logic [DATA_WIDTH-1:0]       dram_rdata;
  logic [VRAM_AW-1:0]          vram_addr;
  logic [7:0]                  vram_wdata;
  logic                        vram_we;
  logic                        vram_re;
  logic [7:0]                  vram_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  modport slave (
    input  display_on, cpu_addr, cpu_wdata, cpu_we, cpu_re, dram_rdata, vram_rdata,
    output cpu_rdata, cpu_wait, dram_addr, dram_we, dram_re,
           vram_addr, vram_wdata, vram_we, vram_re, fifo_level
  );

  modport master (
    output display_on, cpu_addr, cpu_wdata, cpu_we, cpu_re, dram_rdata, vram_rdata,
    input  cpu_rdata, cpu_wait, dram_addr, dram_we, dram_re,
           vram_addr, vram_wdata, vram_we, vram_re, fifo_level
  );
endinterface

// File: rtl/mcpu_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; level = wptr - rptr.
// Push while full and pop while empty are ignored.
module mcpu_sync_fifo #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW:0]    wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer update; reset discards all queued entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[PtrW-1:0]] <= data_i;
  end

  // Status and head-of-queue outputs.
  always_comb begin
    level_o = wptr_q - rptr_q;
    empty_o = (wptr_q == rptr_q);
    full_o  = (level_o == (PtrW + 1)'(DEPTH));
    data_o  = mem_q[rptr_q[PtrW-1:0]];
  end
endmodule

// File: rtl/mcpu_vram_arbiter.sv
// CPU data-port arbiter between DRAM (zero-wait pass-through) and VRAM
// (buffered writes drained during blanking, stalled reads).
// Optional macro MCPU_VRAM_ARB_STATS_EN adds a saturating stall_cnt output.
module mcpu_vram_arbiter
  import mcpu_bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned VRAM_AW    = 13
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef MCPU_VRAM_ARB_STATS_EN
  output logic [15:0]          stall_cnt,
`endif
  mcpu_vram_arbiter_if.slave   bus
);
  localparam int unsigned EntryW = fifo_entry_w(VRAM_AW);
  localparam int unsigned LvlW   = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]         region;
  logic               is_dram, is_vram, wr_vram, rd_vram, rd_any;
  logic               push, pop, full, empty;
  logic [LvlW-1:0]    level;
  logic [EntryW-1:0]  head, entry;
  arb_state_e         state_q;
  logic [VRAM_AW-1:0] rd_addr_q;
  logic [7:0]         rdata_q;

  // Region decode; a write always wins over a simultaneous read.
  always_comb begin
    region  = bus.cpu_addr[DATA_WIDTH-1 -: 2];
    is_dram = (region == REGION_DRAM);
    is_vram = (region == REGION_VRAM);
    rd_any  = bus.cpu_re & ~bus.cpu_we;
    wr_vram = bus.cpu_we & is_vram;
    rd_vram = rd_any & is_vram;
    entry   = {bus.cpu_addr[VRAM_AW-1:0], bus.cpu_wdata[7:0]};
    push    = wr_vram & ~full & (state_q == StIdle);
    // Drain keeps running while a read waits for the buffer to empty.
    pop     = ~empty & ~bus.display_on & ((state_q == StIdle) || (state_q == StRdPend));
  end

  mcpu_sync_fifo #(
    .WIDTH (EntryW),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .data_i  (entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // Read FSM: latch address, wait for empty buffer and blanking, issue, return data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      rd_addr_q <= '0;
      rdata_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rd_vram) begin
            rd_addr_q <= bus.cpu_addr[VRAM_AW-1:0];
            state_q   <= StRdPend;
          end
        end
        StRdPend: begin
          if (empty && !bus.display_on) state_q <= StRdIssue;
        end
        StRdIssue: state_q <= StRdDone;
        StRdDone: begin
          rdata_q <= bus.vram_rdata;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Bus outputs. In RdDone the fresh VRAM byte is forwarded so the CPU sees it
  // in the same cycle its stall is released; afterwards the captured copy holds.
  always_comb begin
    bus.dram_addr  = bus.cpu_addr[DATA_WIDTH-3:0];
    bus.dram_we    = bus.cpu_we & is_dram;
    bus.dram_re    = rd_any & is_dram;
    bus.vram_we    = pop;
    bus.vram_re    = (state_q == StRdIssue);
    bus.vram_addr  = bus.vram_re ? rd_addr_q : head[EntryW-1:8];
    bus.vram_wdata = head[7:0];
    bus.fifo_level = level;
    bus.cpu_wait   = (wr_vram & full) | ((state_q == StIdle) & rd_vram) |
                     (state_q == StRdPend) | (state_q == StRdIssue);
    if (rd_any && is_dram) begin
      bus.cpu_rdata = bus.dram_rdata;
    end else if (state_q == StRdDone) begin
      bus.cpu_rdata = {{(DATA_WIDTH-8){1'b0}}, bus.vram_rdata};
    end else if (rd_any && !is_vram) begin
      bus.cpu_rdata = '0;
    end else begin
      bus.cpu_rdata = {{(DATA_WIDTH-8){1'b0}}, rdata_q};
    end
  end

`ifdef MCPU_VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of stalled CPU cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (bus.cpu_wait && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mcpu_vram_arbiter.sv
// Directed bench for mcpu_vram_arbiter with a synchronous-read VRAM model.
module tb_mcpu_vram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   viol = 0;
  int   vram_wr_cnt = 0;
  logic [7:0] vmem [8192];
  logic [7:0] vram_rd_q;

  mcpu_vram_arbiter_if #(.DATA_WIDTH(16), .VRAM_AW(13), .FIFO_DEPTH(4)) bus ();

`ifdef MCPU_VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  mcpu_vram_arbiter #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .VRAM_AW(13)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef MCPU_VRAM_ARB_STATS_EN
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  assign bus.vram_rdata = vram_rd_q;

  // VRAM model plus protocol monitor.
  always @(posedge clk) begin
    if (bus.vram_we) vmem[bus.vram_addr] <= bus.vram_wdata;
    if (bus.vram_re) vram_rd_q <= vmem[bus.vram_addr];
    if (!reset) begin
      if (bus.vram_we) vram_wr_cnt++;
      if (bus.vram_we && bus.vram_re) viol++;
      if (bus.vram_we && bus.display_on) viol++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus;
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b0;
    bus.cpu_addr = 16'h0000;
    bus.cpu_wdata = 16'h0000;
  endtask

  task automatic test_reset;
    n_cmp++; if (bus.fifo_level !== 3'd0) begin n_fail++;
      $display("FAIL reset_level got %0d required 0", bus.fifo_level); end
    n_cmp++; if (bus.cpu_wait !== 1'b0) begin n_fail++;
      $display("FAIL reset_wait got %b required 0", bus.cpu_wait); end
    n_cmp++; if (bus.cpu_rdata !== 16'h0000) begin n_fail++;
      $display("FAIL reset_rdata got %h required 0000", bus.cpu_rdata); end
    n_cmp++; if ({bus.vram_we, bus.vram_re, bus.dram_we, bus.dram_re} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes got %b required 0000",
                         {bus.vram_we, bus.vram_re, bus.dram_we, bus.dram_re}); end
    reset = 1'b0;
    step();
    // Queue three writes while the GPU owns VRAM, then reset mid-queue.
    for (int i = 0; i < 3; i++) begin
      bus.cpu_we = 1'b1;
      bus.cpu_addr = 16'h4001 + 16'(i);
      bus.cpu_wdata = 16'h0011 + 16'(i);
      step();
    end
    idle_bus();
    n_cmp++; if (bus.fifo_level !== 3'd3) begin n_fail++;
      $display("FAIL reset_queue_level got %0d required 3", bus.fifo_level); end
    begin
      int snap;
      snap = vram_wr_cnt;
      bus.display_on = 1'b0;
      reset = 1'b1;
      #1;
      n_cmp++; if (bus.fifo_level !== 3'd0) begin n_fail++;
        $display("FAIL reset_flush_level got %0d required 0", bus.fifo_level); end
      n_cmp++; if (bus.vram_we !== 1'b0) begin n_fail++;
        $display("FAIL reset_flush_we got %b required 0", bus.vram_we); end
      step();
      reset = 1'b0;
      repeat (3) step();
      n_cmp++; if (vram_wr_cnt !== snap) begin n_fail++;
        $display("FAIL reset_no_vram_writes got %0d required %0d", vram_wr_cnt, snap); end
      n_cmp++; if (vmem[13'h0001] !== 8'h00) begin n_fail++;
        $display("FAIL reset_vmem1 got %h required 00", vmem[13'h0001]); end
    end
  endtask

  task automatic test_buffered_write;
    bus.display_on = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 16'h4010;
    bus.cpu_wdata = 16'h0041;
    #2;
    n_cmp++; if (bus.cpu_wait !== 1'b0) begin n_fail++;
      $display("FAIL bw_wait got %b required 0", bus.cpu_wait); end
    step();
    idle_bus();
    n_cmp++; if (bus.fifo_level !== 3'd1) begin n_fail++;
      $display("FAIL bw_level got %0d required 1", bus.fifo_level); end
    n_cmp++; if (bus.vram_we !== 1'b0) begin n_fail++;
      $display("FAIL bw_no_we_display got %b required 0", bus.vram_we); end
    bus.display_on = 1'b0;
    #2;
    n_cmp++; if ({bus.vram_we, bus.vram_addr, bus.vram_wdata} !== {1'b1, 13'h0010, 8'h41}) begin
      n_fail++; $display("FAIL bw_drain got we=%b addr=%h data=%h required 1/0010/41",
                         bus.vram_we, bus.vram_addr, bus.vram_wdata); end
    step();
    n_cmp++; if (bus.fifo_level !== 3'd0) begin n_fail++;
      $display("FAIL bw_level_after got %0d required 0", bus.fifo_level); end
    n_cmp++; if (vmem[13'h0010] !== 8'h41) begin n_fail++;
      $display("FAIL bw_vmem got %h required 41", vmem[13'h0010]); end
  endtask

  task automatic test_full;
    bus.display_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.cpu_we = 1'b1;
      bus.cpu_addr = 16'h4100 + 16'(i);
      bus.cpu_wdata = 16'h00A0 + 16'(i);
      #2;
      n_cmp++; if (bus.cpu_wait !== 1'b0) begin n_fail++;
        $display("FAIL full_fill_wait%0d got %b required 0", i, bus.cpu_wait); end
      step();
    end
    bus.cpu_addr = 16'h4104;
    bus.cpu_wdata = 16'h00A4;
    #2;
    n_cmp++; if (bus.cpu_wait !== 1'b1) begin n_fail++;
      $display("FAIL full_fifth_wait got %b required 1", bus.cpu_wait); end
    step();
    n_cmp++; if ({bus.fifo_level, bus.cpu_wait} !== {3'd4, 1'b1}) begin n_fail++;
      $display("FAIL full_hold got level=%0d wait=%b required 4/1", bus.fifo_level, bus.cpu_wait); end
    bus.display_on = 1'b0;
    #2;
    n_cmp++; if ({bus.vram_we, bus.vram_addr, bus.cpu_wait} !== {1'b1, 13'h0100, 1'b1}) begin
      n_fail++; $display("FAIL full_first_pop got we=%b addr=%h wait=%b required 1/0100/1",
                         bus.vram_we, bus.vram_addr, bus.cpu_wait); end
    step();
    n_cmp++; if ({bus.fifo_level, bus.cpu_wait} !== {3'd3, 1'b0}) begin n_fail++;
      $display("FAIL full_slot_free got level=%0d wait=%b required 3/0", bus.fifo_level, bus.cpu_wait); end
    step();
    idle_bus();
    n_cmp++; if (bus.fifo_level !== 3'd3) begin n_fail++;
      $display("FAIL full_push_pop_level got %0d required 3", bus.fifo_level); end
    for (int i = 0; i < 10 && bus.fifo_level != 3'd0; i++) step();
    n_cmp++; if (bus.fifo_level !== 3'd0) begin n_fail++;
      $display("FAIL full_drain_timeout got %0d required 0", bus.fifo_level); end
    n_cmp++; if ({vmem[13'h0100], vmem[13'h0103], vmem[13'h0104]} !== {8'hA0, 8'hA3, 8'hA4}) begin
      n_fail++; $display("FAIL full_vmem got %h %h %h required A0 A3 A4",
                         vmem[13'h0100], vmem[13'h0103], vmem[13'h0104]); end
  endtask

  task automatic test_read_order;
    bus.display_on = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 16'h4020;
    bus.cpu_wdata = 16'h005A;
    step();
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b1;
    #2;
    n_cmp++; if (bus.cpu_wait !== 1'b1) begin n_fail++;
      $display("FAIL rd_req_wait got %b required 1", bus.cpu_wait); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if ({bus.cpu_wait, bus.vram_re, bus.fifo_level} !== {1'b1, 1'b0, 3'd1}) begin
        n_fail++; $display("FAIL rd_pend%0d got wait=%b re=%b level=%0d required 1/0/1",
                           i, bus.cpu_wait, bus.vram_re, bus.fifo_level); end
    end
    bus.display_on = 1'b0;
    #2;
    n_cmp++; if ({bus.vram_we, bus.vram_re, bus.vram_addr} !== {1'b1, 1'b0, 13'h0020}) begin
      n_fail++; $display("FAIL rd_drain_first got we=%b re=%b addr=%h required 1/0/0020",
                         bus.vram_we, bus.vram_re, bus.vram_addr); end
    step();
    n_cmp++; if ({bus.fifo_level, bus.vram_we, bus.vram_re, bus.cpu_wait} !== {3'd0, 3'b001}) begin
      n_fail++; $display("FAIL rd_empty got level=%0d we=%b re=%b wait=%b required 0/0/0/1",
                         bus.fifo_level, bus.vram_we, bus.vram_re, bus.cpu_wait); end
    step();
    n_cmp++; if ({bus.vram_re, bus.vram_we, bus.vram_addr, bus.cpu_wait}
                 !== {1'b1, 1'b0, 13'h0020, 1'b1}) begin
      n_fail++; $display("FAIL rd_issue got re=%b we=%b addr=%h wait=%b required 1/0/0020/1",
                         bus.vram_re, bus.vram_we, bus.vram_addr, bus.cpu_wait); end
    step();
    n_cmp++; if ({bus.cpu_wait, bus.cpu_rdata} !== {1'b0, 16'h005A}) begin n_fail++;
      $display("FAIL rd_done got wait=%b rdata=%h required 0/005A", bus.cpu_wait, bus.cpu_rdata); end
    step();
    bus.cpu_re = 1'b0;
    #2;
    n_cmp++; if (bus.cpu_rdata !== 16'h005A) begin n_fail++;
      $display("FAIL rd_hold got %h required 005A", bus.cpu_rdata); end
    idle_bus();
  endtask

  task automatic test_dram;
    bus.dram_rdata = 16'hBEEF;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 16'h0123;
    bus.cpu_wdata = 16'h1234;
    #2;
    n_cmp++; if ({bus.dram_we, bus.dram_re, bus.dram_addr, bus.cpu_wait, bus.vram_we}
                 !== {2'b10, 14'h0123, 2'b00}) begin
      n_fail++; $display("FAIL dram_write got we=%b re=%b addr=%h wait=%b vwe=%b required 1/0/0123/0/0",
                         bus.dram_we, bus.dram_re, bus.dram_addr, bus.cpu_wait, bus.vram_we); end
    step();
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b1;
    #2;
    n_cmp++; if ({bus.dram_re, bus.dram_we, bus.cpu_rdata, bus.cpu_wait} !== {2'b10, 16'hBEEF, 1'b0}) begin
      n_fail++; $display("FAIL dram_read got re=%b we=%b rdata=%h wait=%b required 1/0/BEEF/0",
                         bus.dram_re, bus.dram_we, bus.cpu_rdata, bus.cpu_wait); end
    n_cmp++; if (bus.fifo_level !== 3'd0) begin n_fail++;
      $display("FAIL dram_no_push got %0d required 0", bus.fifo_level); end
    step();
    idle_bus();
  endtask

  task automatic test_reserved;
`ifdef MCPU_VRAM_ARB_STATS_EN
    logic [15:0] snap;
`endif
    bus.display_on = 1'b1;
    bus.cpu_re = 1'b1;
    bus.cpu_addr = 16'h8000;
    #2;
`ifdef MCPU_VRAM_ARB_STATS_EN
    snap = stall_cnt;
`endif
    n_cmp++; if ({bus.cpu_rdata, bus.cpu_wait, bus.dram_we, bus.dram_re, bus.vram_we, bus.vram_re}
                 !== {16'h0000, 5'b00000}) begin
      n_fail++; $display("FAIL rsv_read got rdata=%h wait=%b strobes=%b required 0000/0/0000",
                         bus.cpu_rdata, bus.cpu_wait,
                         {bus.dram_we, bus.dram_re, bus.vram_we, bus.vram_re}); end
    step();
`ifdef MCPU_VRAM_ARB_STATS_EN
    n_cmp++; if (stall_cnt !== snap) begin n_fail++;
      $display("FAIL rsv_stall_cnt got %h required %h", stall_cnt, snap); end
`endif
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 16'hC000;
    bus.cpu_wdata = 16'h00EE;
    step();
    idle_bus();
    n_cmp++; if ({bus.fifo_level, bus.cpu_wait} !== {3'd0, 1'b0}) begin n_fail++;
      $display("FAIL rsv_write_dropped got level=%0d wait=%b required 0/0",
               bus.fifo_level, bus.cpu_wait); end
  endtask

  task automatic test_we_wins;
    bus.display_on = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_re = 1'b1;
    bus.cpu_addr = 16'h4030;
    bus.cpu_wdata = 16'h0077;
    #2;
    n_cmp++; if (bus.cpu_wait !== 1'b0) begin n_fail++;
      $display("FAIL wewins_wait got %b required 0", bus.cpu_wait); end
    step();
    idle_bus();
    n_cmp++; if ({bus.fifo_level, bus.cpu_wait} !== {3'd1, 1'b0}) begin n_fail++;
      $display("FAIL wewins_push got level=%0d wait=%b required 1/0", bus.fifo_level, bus.cpu_wait); end
    bus.display_on = 1'b0;
    step();
    step();
    n_cmp++; if ({bus.fifo_level, bus.vram_re, vmem[13'h0030]} !== {3'd0, 1'b0, 8'h77}) begin
      n_fail++; $display("FAIL wewins_drain got level=%0d re=%b vmem=%h required 0/0/77",
                         bus.fifo_level, bus.vram_re, vmem[13'h0030]); end
  endtask

  task automatic test_invariants;
    n_cmp++; if (viol !== 0) begin n_fail++;
      $display("FAIL strobe_invariant got %0d violations required 0", viol); end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) vmem[i] = 8'h00;
    vram_rd_q = 8'h00;
    bus.display_on = 1'b1;
    bus.dram_rdata = 16'h0000;
    idle_bus();
    step();
    test_reset();
    test_buffered_write();
    test_full();
    test_read_order();
    test_dram();
    test_reserved();
    test_we_wins();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
